// File: rtl/move_input_capture_if.sv
// Pin bundle between the raw tic-tac-toe controls and the move capture front end.
// The capture block takes the slave side: it reads the raw pins and drives the clean move event.
interface move_input_capture_if;
  logic       buttonX;
  logic       buttonO;
  logic [8:0] sel_pos;
  logic       move_strobe;
  logic       move_player;
  logic [8:0] move_pos;
  logic       move_multi;
  logic       move_both;

  modport master (
    output buttonX, buttonO, sel_pos,
    input  move_strobe, move_player, move_pos, move_multi, move_both
  );

  modport slave (
    input  buttonX, buttonO, sel_pos,
    output move_strobe, move_player, move_pos, move_multi, move_both
  );
endinterface

// File: rtl/move_input_capture.sv
// Synchronises and debounces the X/O buttons and turns each press into one registered move event
// carrying the captured position, the player and the error flags.
module move_input_capture #(
  parameter int DB_CYCLES = 50000,
  parameter int DB_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  move_input_capture_if.slave bus
);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    HELD = 2'd2
  } state_t;

  localparam logic [DB_W-1:0] DbLast   = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0] InitLast = DB_W'(DB_CYCLES + 2);

  logic [1:0]      syncX_q, syncO_q;
  logic [8:0]      posMeta_q, posSync_q;
  logic            dbX_q, dbO_q, dbX_d, dbO_d;
  logic            dbXPrev_q, dbOPrev_q;
  logic [DB_W-1:0] cntX_q, cntO_q, cntX_d, cntO_d;
  logic [DB_W-1:0] initCnt_q, initCnt_d;
  state_t          state_q, state_d;
  logic            pendX_q, pendO_q, pendX_d, pendO_d;
  logic            riseX, riseO, reqX, reqO, emitReq, emit;
  logic            strobe_q, player_q, multi_q, both_q;
  logic [8:0]      pos_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      syncX_q   <= '0;
      syncO_q   <= '0;
      posMeta_q <= '0;
      posSync_q <= '0;
    end else begin
      syncX_q   <= {syncX_q[0], bus.buttonX};
      syncO_q   <= {syncO_q[0], bus.buttonO};
      posMeta_q <= bus.sel_pos;
      posSync_q <= posMeta_q;
    end
  end

  // A level only flips after DB_CYCLES consecutive cycles of disagreement.
  always_comb begin
    cntX_d = '0;
    dbX_d  = dbX_q;
    if (syncX_q[1] != dbX_q) begin
      if (cntX_q == DbLast) dbX_d = syncX_q[1];
      else                  cntX_d = cntX_q + 1'b1;
    end
    cntO_d = '0;
    dbO_d  = dbO_q;
    if (syncO_q[1] != dbO_q) begin
      if (cntO_q == DbLast) dbO_d = syncO_q[1];
      else                  cntO_d = cntO_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cntX_q    <= '0;
      cntO_q    <= '0;
      dbX_q     <= 1'b0;
      dbO_q     <= 1'b0;
      dbXPrev_q <= 1'b0;
      dbOPrev_q <= 1'b0;
    end else begin
      cntX_q    <= cntX_d;
      cntO_q    <= cntO_d;
      dbX_q     <= dbX_d;
      dbO_q     <= dbO_d;
      dbXPrev_q <= dbX_q;
      dbOPrev_q <= dbO_q;
    end
  end

  assign riseX = dbX_q & ~dbXPrev_q;
  assign riseO = dbO_q & ~dbOPrev_q;
  assign reqX  = riseX | pendX_q;
  assign reqO  = riseO | pendO_q;

  // A rise landing right after a strobe is held one cycle so strobes never touch.
  always_comb begin
    state_d   = state_q;
    initCnt_d = initCnt_q;
    emitReq   = 1'b0;
    pendX_d   = 1'b0;
    pendO_d   = 1'b0;
    case (state_q)
      INIT: begin
        initCnt_d = initCnt_q + 1'b1;
        if (initCnt_q == InitLast) begin
          initCnt_d = '0;
          state_d   = HELD;
        end
      end
      IDLE: begin
        if (reqX | reqO) begin
          emitReq = 1'b1;
          state_d = HELD;
        end
      end
      HELD: begin
        if (reqX | reqO) emitReq = 1'b1;
        if (!dbX_q && !dbO_q) state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
    if (emitReq && strobe_q) begin
      pendX_d = reqX;
      pendO_d = reqO;
    end
    emit = emitReq & ~strobe_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= INIT;
      initCnt_q <= '0;
      pendX_q   <= 1'b0;
      pendO_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      initCnt_q <= initCnt_d;
      pendX_q   <= pendX_d;
      pendO_q   <= pendO_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      strobe_q <= 1'b0;
      player_q <= 1'b0;
      pos_q    <= '0;
      multi_q  <= 1'b0;
      both_q   <= 1'b0;
    end else begin
      strobe_q <= emit;
      if (emit) begin
        player_q <= reqX;
        pos_q    <= posSync_q;
        multi_q  <= ($countones(posSync_q) != 1);
        both_q   <= dbX_q & dbO_q;
      end
    end
  end

  assign bus.move_strobe = strobe_q;
  assign bus.move_player = player_q;
  assign bus.move_pos    = pos_q;
  assign bus.move_multi  = multi_q;
  assign bus.move_both   = both_q;

endmodule

// File: tb/tb_move_input_capture.sv
// Directed and random checks of move_input_capture against a pin-history reference model.
module tb_move_input_capture;
  localparam int DB_CYCLES = 4;
  localparam int DB_W      = 8;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  move_input_capture_if bus ();

  move_input_capture #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  bit         pinQX[$], pinQO[$];
  logic [8:0] pinQP[$];
  bit         synQX[$], synQO[$];
  bit         mInReset, mDbX, mDbXPrev, mDbO, mDbOPrev, mPendX, mPendO;
  bit         mStrobe, mPlayer, mMulti, mBoth;
  logic [8:0] mPos;
  int         mCycle;
  int         seenStrobes, firstStrobeAt, stepIdx;

  function automatic bit lagged(input bit q[$]);
    return (q.size() >= 2) ? q[q.size()-2] : 1'b0;
  endfunction

  function automatic logic [8:0] laggedPos(input logic [8:0] q[$]);
    return (q.size() >= 2) ? q[q.size()-2] : 9'h000;
  endfunction

  // True when every one of the last DB_CYCLES synced samples disagrees with the current level.
  function automatic bit windowFlip(input bit q[$], input bit db);
    if (q.size() < DB_CYCLES) return 1'b0;
    for (int i = 1; i <= DB_CYCLES; i++)
      if (q[q.size()-i] == db) return 1'b0;
    return 1'b1;
  endfunction

  task automatic modelReset();
    pinQX.delete(); pinQO.delete(); pinQP.delete();
    synQX.delete(); synQO.delete();
    mDbX = 0; mDbXPrev = 0; mDbO = 0; mDbOPrev = 0; mPendX = 0; mPendO = 0;
    mStrobe = 0; mPlayer = 0; mMulti = 0; mBoth = 0; mPos = '0; mCycle = 0;
  endtask

  task automatic modelEdge();
    bit sx, so, rX, rO, reqX, reqO, inInit, evt, newX, newO;
    logic [8:0] sp;
    if (mInReset) return;
    sx = lagged(pinQX);
    so = lagged(pinQO);
    sp = laggedPos(pinQP);
    rX = mDbX && !mDbXPrev;
    rO = mDbO && !mDbOPrev;
    reqX = rX || mPendX;
    reqO = rO || mPendO;
    inInit = (mCycle <= DB_CYCLES + 2);
    evt = !inInit && (reqX || reqO) && !mStrobe;
    mPendX = !inInit && mStrobe && reqX;
    mPendO = !inInit && mStrobe && reqO;
    mStrobe = evt;
    if (evt) begin
      mPlayer = reqX;
      mPos    = sp;
      mMulti  = ($countones(sp) != 1);
      mBoth   = mDbX && mDbO;
    end
    synQX.push_back(sx);
    synQO.push_back(so);
    newX = windowFlip(synQX, mDbX) ? !mDbX : mDbX;
    newO = windowFlip(synQO, mDbO) ? !mDbO : mDbO;
    mDbXPrev = mDbX; mDbX = newX;
    mDbOPrev = mDbO; mDbO = newO;
    pinQX.push_back(bus.buttonX);
    pinQO.push_back(bus.buttonO);
    pinQP.push_back(bus.sel_pos);
    while (pinQX.size() > 4) begin
      void'(pinQX.pop_front()); void'(pinQO.pop_front()); void'(pinQP.pop_front());
    end
    while (synQX.size() > 16) begin
      void'(synQX.pop_front()); void'(synQO.pop_front());
    end
    mCycle++;
  endtask

  task automatic checkValue(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkCount(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, "_strobe"}, 9'(bus.move_strobe), 9'(mStrobe));
    checkValue({tag, "_player"}, 9'(bus.move_player), 9'(mPlayer));
    checkValue({tag, "_pos"},    bus.move_pos,        mPos);
    checkValue({tag, "_multi"},  9'(bus.move_multi),  9'(mMulti));
    checkValue({tag, "_both"},   9'(bus.move_both),   9'(mBoth));
  endtask

  task automatic clearWatch();
    seenStrobes = 0;
    firstStrobeAt = -1;
    stepIdx = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    modelEdge();
    #1;
    stepIdx++;
    if (bus.move_strobe === 1'b1) begin
      seenStrobes++;
      if (firstStrobeAt < 0) firstStrobeAt = stepIdx;
    end
    checkOutput("cyc");
  endtask

  task automatic applyStimulus(input bit x, input bit o, input logic [8:0] p, input int n);
    bus.buttonX = x;
    bus.buttonO = o;
    bus.sel_pos = p;
    repeat (n) cycle();
  endtask

  task automatic resetAssert();
    reset = 1'b0;
    modelReset();
    mInReset = 1'b1;
    #1;
    checkOutput("rst");
  endtask

  task automatic resetRelease();
    reset = 1'b1;
    mInReset = 1'b0;
  endtask

  initial begin
    logic [8:0] p;
    bit         rx, ro;
    int         n;
    bus.buttonX = 1'b0;
    bus.buttonO = 1'b0;
    bus.sel_pos = '0;
    clearWatch();
    resetAssert();
    applyStimulus(0, 0, 9'h000, 3);
    resetRelease();
    applyStimulus(0, 0, 9'h010, 10);

    $display("[TB] single X press");
    clearWatch();
    applyStimulus(1, 0, 9'h010, 20);
    checkCount("s1_count", seenStrobes, 1);
    checkCount("s1_latency", firstStrobeAt, 7);
    checkValue("s1_player", 9'(bus.move_player), 9'h001);
    checkValue("s1_pos", bus.move_pos, 9'h010);
    checkValue("s1_multi", 9'(bus.move_multi), 9'h000);
    checkValue("s1_both", 9'(bus.move_both), 9'h000);
    applyStimulus(0, 0, 9'h010, 10);

    $display("[TB] short O pulse and bounce");
    clearWatch();
    applyStimulus(0, 1, 9'h080, 3);
    applyStimulus(0, 0, 9'h080, 2);
    applyStimulus(0, 1, 9'h080, 1);
    applyStimulus(0, 0, 9'h080, 10);
    checkCount("s2_count", seenStrobes, 0);
    checkValue("s2_pos_held", bus.move_pos, 9'h010);
    checkValue("s2_player_held", 9'(bus.move_player), 9'h001);

    $display("[TB] O press with bad positions");
    clearWatch();
    applyStimulus(0, 1, 9'h011, 12);
    checkCount("s3a_count", seenStrobes, 1);
    checkValue("s3a_player", 9'(bus.move_player), 9'h000);
    checkValue("s3a_multi", 9'(bus.move_multi), 9'h001);
    applyStimulus(0, 0, 9'h011, 10);
    clearWatch();
    applyStimulus(0, 1, 9'h000, 12);
    checkCount("s3b_count", seenStrobes, 1);
    checkValue("s3b_multi", 9'(bus.move_multi), 9'h001);
    checkValue("s3b_pos", bus.move_pos, 9'h000);
    applyStimulus(0, 0, 9'h000, 10);

    $display("[TB] X held then O");
    clearWatch();
    applyStimulus(1, 0, 9'h100, 5);
    applyStimulus(1, 1, 9'h100, 12);
    checkCount("s4_count", seenStrobes, 2);
    checkValue("s4_player", 9'(bus.move_player), 9'h000);
    checkValue("s4_both", 9'(bus.move_both), 9'h001);
    clearWatch();
    applyStimulus(0, 0, 9'h100, 12);
    checkCount("s4_release_count", seenStrobes, 0);
    applyStimulus(1, 0, 9'h001, 12);
    checkCount("s4_idle_count", seenStrobes, 1);
    checkValue("s4_idle_both", 9'(bus.move_both), 9'h000);
    applyStimulus(0, 0, 9'h001, 10);

    $display("[TB] X held through reset");
    applyStimulus(1, 0, 9'h040, 12);
    resetAssert();
    applyStimulus(1, 0, 9'h040, 3);
    resetRelease();
    clearWatch();
    applyStimulus(1, 0, 9'h040, 20);
    checkCount("s5_held_count", seenStrobes, 0);
    applyStimulus(0, 0, 9'h040, 10);
    applyStimulus(1, 0, 9'h040, 10);
    checkCount("s5_repress_count", seenStrobes, 1);
    applyStimulus(0, 0, 9'h040, 10);

    $display("[TB] reset just before a strobe");
    applyStimulus(0, 0, 9'h002, 4);
    clearWatch();
    applyStimulus(1, 0, 9'h002, 5);
    resetAssert();
    checkValue("s6_pos_zero", bus.move_pos, 9'h000);
    applyStimulus(0, 0, 9'h002, 3);
    resetRelease();
    applyStimulus(0, 0, 9'h002, 15);
    checkCount("s6_count", seenStrobes, 0);

    $display("[TB] random traffic");
    for (int seg = 0; seg < 120; seg++) begin
      if ($urandom_range(0, 29) == 0) begin
        resetAssert();
        applyStimulus(bus.buttonX, bus.buttonO, bus.sel_pos, 2);
        resetRelease();
      end
      case ($urandom_range(0, 3))
        0:       p = 9'h001 << $urandom_range(0, 8);
        1:       p = 9'h000;
        2:       p = 9'($urandom);
        default: p = 9'h100 >> $urandom_range(0, 8);
      endcase
      rx = 1'($urandom_range(0, 1));
      ro = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 12);
      applyStimulus(rx, ro, p, n);
    end
    applyStimulus(0, 0, 9'h000, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
